// File: rtl/writeback_pkg.sv
// Shared constants, the write-request record and counter sizing for the writeback path.
package writeback_pkg;

  localparam int REG_W = 5;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_req_t;

  function automatic int cnt_w(input int max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/load_scoreboard.sv
// Pending-load bit per register plus an outstanding-load counter; lookups are combinational.
// Issue is refused at MAX_OUTSTANDING; a response with nothing outstanding latches err_o.
module load_scoreboard
  import writeback_pkg::*;
#(
  parameter int NREGS           = writeback_pkg::NREGS,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             issue_load_i,
  input  logic [REG_W-1:0] issue_rd_i,
  input  logic             rsp_acc_i,
  input  logic [REG_W-1:0] rsp_rd_i,
  input  logic [REG_W-1:0] rs1_sel_i,
  input  logic [REG_W-1:0] rs2_sel_i,
  output logic             issue_ready_o,
  output logic             rs1_pend_o,
  output logic             rs2_pend_o,
  output logic             issue_pend_o,
  output logic             err_o
);

  localparam int CW = cnt_w(MAX_OUTSTANDING);

  logic [NREGS-1:0] r_sb;
  logic [NREGS-1:0] w_sb_nxt;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_clr;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             r_err;
  logic             w_issue_acc;

  assign issue_ready_o = r_cnt < CW'(MAX_OUTSTANDING);
  assign w_issue_acc   = issue_load_i && issue_ready_o;
  assign rs1_pend_o    = r_sb[rs1_sel_i];
  assign rs2_pend_o    = r_sb[rs2_sel_i];
  assign issue_pend_o  = r_sb[issue_rd_i];
  assign err_o         = r_err;

  // Set is applied after clear so a same-cycle issue to a retiring register stays pending.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (w_issue_acc) w_set[issue_rd_i] = 1'b1;
    if (rsp_acc_i)   w_clr[rsp_rd_i]   = 1'b1;
    w_sb_nxt    = (r_sb & ~w_clr) | w_set;
    w_sb_nxt[0] = 1'b0;
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_issue_acc && !rsp_acc_i)                  w_cnt_nxt = r_cnt + CW'(1);
    else if (!w_issue_acc && rsp_acc_i && r_cnt != '0) w_cnt_nxt = r_cnt - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sb  <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_sb  <= w_sb_nxt;
      r_cnt <= w_cnt_nxt;
      if (rsp_acc_i && r_cnt == '0) r_err <= 1'b1;
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Merges ALU results and load responses into one registered RF write (1-cycle latency).
// ALU never stalls and always wins; load responses wait via mem_ready_o, loads via issue_ready_o/hazard_o.
module writeback_unit
  import writeback_pkg::*;
#(
  parameter int XLEN            = writeback_pkg::XLEN,
  parameter int NREGS           = writeback_pkg::NREGS,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             alu_valid_i,
  input  logic [REG_W-1:0] alu_rd_i,
  input  logic [XLEN-1:0]  alu_data_i,
  input  logic             issue_load_i,
  input  logic [REG_W-1:0] issue_rd_i,
  output logic             issue_ready_o,
  input  logic             mem_valid_i,
  input  logic [REG_W-1:0] mem_rd_i,
  input  logic [XLEN-1:0]  mem_data_i,
  output logic             mem_ready_o,
  input  logic [REG_W-1:0] rs1_sel_i,
  input  logic [REG_W-1:0] rs2_sel_i,
  input  logic [XLEN-1:0]  rf_out1_i,
  input  logic [XLEN-1:0]  rf_out2_i,
  output logic [XLEN-1:0]  rs1_data_o,
  output logic [XLEN-1:0]  rs2_data_o,
  output logic             hazard_o,
  output logic [XLEN-1:0]  rf_data_o,
  output logic [REG_W-1:0] rf_sel_o,
  output logic             rf_en_o,
  output logic             err_o
);

  wb_req_t         w_win;
  wb_req_t         r_wb;
  logic            w_rsp_acc;
  logic            w_rs1_pend;
  logic            w_rs2_pend;
  logic            w_issue_pend;
  logic            r_hit1;
  logic            r_hit2;
  logic [XLEN-1:0] r_fwd;

  assign mem_ready_o = !alu_valid_i;
  assign w_rsp_acc   = mem_valid_i && mem_ready_o;

  always_comb begin
    w_win = '0;
    if (alu_valid_i) begin
      w_win.valid = 1'b1;
      w_win.rd    = alu_rd_i;
      w_win.data  = alu_data_i;
    end else if (w_rsp_acc) begin
      w_win.valid = 1'b1;
      w_win.rd    = mem_rd_i;
      w_win.data  = mem_data_i;
    end
  end

  // r_wb.valid is the write enable itself, so x0 winners never raise it.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wb <= '0;
    end else begin
      r_wb.valid <= w_win.valid && (w_win.rd != '0);
      if (w_win.valid) begin
        r_wb.rd   <= w_win.rd;
        r_wb.data <= w_win.data;
      end
    end
  end

  assign rf_en_o   = r_wb.valid;
  assign rf_sel_o  = r_wb.rd;
  assign rf_data_o = r_wb.data;

  // The RF read sampled on the writing edge returns the stale value; substitute the write data for that one cycle.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hit1 <= 1'b0;
      r_hit2 <= 1'b0;
      r_fwd  <= '0;
    end else begin
      r_hit1 <= rf_en_o && (rf_sel_o == rs1_sel_i) && (rs1_sel_i != '0);
      r_hit2 <= rf_en_o && (rf_sel_o == rs2_sel_i) && (rs2_sel_i != '0);
      r_fwd  <= rf_data_o;
    end
  end

  assign rs1_data_o = r_hit1 ? r_fwd : rf_out1_i;
  assign rs2_data_o = r_hit2 ? r_fwd : rf_out2_i;

  assign hazard_o = w_rs1_pend | w_rs2_pend
                  | (issue_load_i & w_issue_pend)
                  | (issue_load_i & !issue_ready_o);

  load_scoreboard #(
    .NREGS          (NREGS),
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_sb (
    .clk          (clk),
    .rst_ni       (rst_ni),
    .issue_load_i (issue_load_i),
    .issue_rd_i   (issue_rd_i),
    .rsp_acc_i    (w_rsp_acc),
    .rsp_rd_i     (mem_rd_i),
    .rs1_sel_i    (rs1_sel_i),
    .rs2_sel_i    (rs2_sel_i),
    .issue_ready_o(issue_ready_o),
    .rs1_pend_o   (w_rs1_pend),
    .rs2_pend_o   (w_rs2_pend),
    .issue_pend_o (w_issue_pend),
    .err_o        (err_o)
  );

endmodule

// File: tb/tb_writeback_unit.sv
// Directed vector table, reset sequence, then random traffic against a queue-based reference model.
module tb_writeback_unit;

  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        alu_valid_i;
  logic [4:0]  alu_rd_i;
  logic [31:0] alu_data_i;
  logic        issue_load_i;
  logic [4:0]  issue_rd_i;
  logic        issue_ready_o;
  logic        mem_valid_i;
  logic [4:0]  mem_rd_i;
  logic [31:0] mem_data_i;
  logic        mem_ready_o;
  logic [4:0]  rs1_sel_i, rs2_sel_i;
  logic [31:0] rf_out1_i = '0;
  logic [31:0] rf_out2_i = '0;
  logic [31:0] rs1_data_o, rs2_data_o;
  logic        hazard_o;
  logic [31:0] rf_data_o;
  logic [4:0]  rf_sel_o;
  logic        rf_en_o;
  logic        err_o;

  int n_tests = 0;
  int n_fail  = 0;

  writeback_unit dut (
    .clk(clk), .rst_ni(rst_ni),
    .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
    .issue_load_i(issue_load_i), .issue_rd_i(issue_rd_i), .issue_ready_o(issue_ready_o),
    .mem_valid_i(mem_valid_i), .mem_rd_i(mem_rd_i), .mem_data_i(mem_data_i), .mem_ready_o(mem_ready_o),
    .rs1_sel_i(rs1_sel_i), .rs2_sel_i(rs2_sel_i), .rf_out1_i(rf_out1_i), .rf_out2_i(rf_out2_i),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .hazard_o(hazard_o),
    .rf_data_o(rf_data_o), .rf_sel_o(rf_sel_o), .rf_en_o(rf_en_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Environment register file: synchronous read returns the pre-write value.
  logic [31:0] tbrf [32] = '{default: '0};
  always @(posedge clk) begin
    rf_out1_i <= tbrf[rs1_sel_i];
    rf_out2_i <= tbrf[rs2_sel_i];
    if (rf_en_o) tbrf[rf_sel_o] <= rf_data_o;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic iv, input logic [4:0] ird,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic [4:0] r1, input logic [4:0] r2);
    alu_valid_i = av; alu_rd_i = ard; alu_data_i = ad;
    issue_load_i = iv; issue_rd_i = ird;
    mem_valid_i = mv; mem_rd_i = mrd; mem_data_i = md;
    rs1_sel_i = r1; rs2_sel_i = r2;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic av; logic [4:0] ard; logic [31:0] ad;
    logic iv; logic [4:0] ird;
    logic mv; logic [4:0] mrd; logic [31:0] md;
    logic [4:0] rs1;
    logic mrdy, haz, rdy;
    logic en; logic [4:0] sel; logic [31:0] dat;
    logic rsc; logic [31:0] rs1d;
    logic err;
  } vec_t;

  function automatic vec_t mk(logic av, logic [4:0] ard, logic [31:0] ad, logic iv, logic [4:0] ird,
                              logic mv, logic [4:0] mrd, logic [31:0] md, logic [4:0] rs1,
                              logic mrdy, logic haz, logic rdy, logic en, logic [4:0] sel,
                              logic [31:0] dat, logic rsc, logic [31:0] rs1d, logic err);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad; v.iv = iv; v.ird = ird;
    v.mv = mv; v.mrd = mrd; v.md = md; v.rs1 = rs1;
    v.mrdy = mrdy; v.haz = haz; v.rdy = rdy; v.en = en; v.sel = sel; v.dat = dat;
    v.rsc = rsc; v.rs1d = rs1d; v.err = err;
    return v;
  endfunction

  vec_t tbl[$];

  // Reference model state for the random phase
  bit          pend [32];
  int          cnt;
  logic [4:0]  outq[$];
  logic [31:0] arch [32];
  logic        pw_en;
  logic [4:0]  pw_sel;
  logic [31:0] pw_data;

  initial begin
    logic av, iv, hold, acc, exp_haz;
    logic [4:0] ard, ird, r1, r2, hrd;
    logic [31:0] ad, hd, e1, e2;
    int hidx;

    //        alu            issue   mem              rs1  mrdy haz rdy  en sel data      rsc rs1d     err
    tbl.push_back(mk(1,5,'h1234, 0,0,  0,0,0,          0,  0,0,1, 1,5,'h1234, 1,0,       0));
    tbl.push_back(mk(0,0,0,      0,0,  0,0,0,          5,  1,0,1, 0,0,0,      1,'h1234,  0));
    tbl.push_back(mk(0,0,0,      0,0,  0,0,0,          5,  1,0,1, 0,0,0,      1,'h1234,  0));
    tbl.push_back(mk(1,0,'hFFFF, 0,0,  0,0,0,          0,  0,0,1, 0,0,0,      1,0,       0));
    tbl.push_back(mk(0,0,0,      0,0,  0,0,0,          0,  1,0,1, 0,0,0,      1,0,       0));
    tbl.push_back(mk(0,0,0,      1,7,  0,0,0,          0,  1,0,1, 0,0,0,      0,0,       0));
    tbl.push_back(mk(0,0,0,      0,0,  0,0,0,          7,  1,1,1, 0,0,0,      0,0,       0));
    tbl.push_back(mk(0,0,0,      0,0,  1,7,'hCAFE,     7,  1,1,1, 1,7,'hCAFE, 0,0,       0));
    tbl.push_back(mk(0,0,0,      0,0,  0,0,0,          7,  1,0,1, 0,0,0,      1,'hCAFE,  0));
    tbl.push_back(mk(0,0,0,      1,9,  0,0,0,          0,  1,0,1, 0,0,0,      0,0,       0));
    tbl.push_back(mk(1,3,'hA1,   0,0,  1,9,'hB2,       0,  0,0,1, 1,3,'hA1,   0,0,       0));
    tbl.push_back(mk(0,0,0,      0,0,  1,9,'hB2,       0,  1,0,1, 1,9,'hB2,   0,0,       0));
    tbl.push_back(mk(0,0,0,      0,0,  0,0,0,          0,  1,0,1, 0,0,0,      0,0,       0));
    for (int k = 1; k <= 4; k++)
      tbl.push_back(mk(0,0,0,    1,5'(k), 0,0,0,       0,  1,0,1, 0,0,0,      0,0,       0));
    tbl.push_back(mk(0,0,0,      1,10, 0,0,0,          0,  1,1,0, 0,0,0,      0,0,       0));
    tbl.push_back(mk(0,0,0,      0,0,  1,1,'h11,       0,  1,0,0, 1,1,'h11,   0,0,       0));
    tbl.push_back(mk(0,0,0,      1,6,  1,2,'h22,       0,  1,0,1, 1,2,'h22,   0,0,       0));
    tbl.push_back(mk(0,0,0,      0,0,  0,0,0,          0,  1,0,1, 0,0,0,      0,0,       0));
    tbl.push_back(mk(0,0,0,      1,8,  0,0,0,          0,  1,0,1, 0,0,0,      0,0,       0));
    tbl.push_back(mk(0,0,0,      0,0,  0,0,0,          0,  1,0,0, 0,0,0,      0,0,       0));
    tbl.push_back(mk(0,0,0,      0,0,  1,3,'h33,       0,  1,0,0, 1,3,'h33,   0,0,       0));
    tbl.push_back(mk(0,0,0,      0,0,  1,4,'h44,       0,  1,0,1, 1,4,'h44,   0,0,       0));
    tbl.push_back(mk(0,0,0,      0,0,  1,6,'h66,       0,  1,0,1, 1,6,'h66,   0,0,       0));
    tbl.push_back(mk(0,0,0,      0,0,  1,8,'h88,       0,  1,0,1, 1,8,'h88,   0,0,       0));
    tbl.push_back(mk(0,0,0,      0,0,  0,0,0,          8,  1,0,1, 0,0,0,      1,'h88,    0));
    tbl.push_back(mk(0,0,0,      0,0,  1,12,'h77,      0,  1,0,1, 1,12,'h77,  0,0,       1));
    tbl.push_back(mk(0,0,0,      0,0,  0,0,0,          0,  1,0,1, 0,0,0,      0,0,       1));

    rst_ni = 1'b0;
    drive(0,0,0, 0,0, 0,0,0, 0,0);
    #12 rst_ni = 1'b1;
    step;
    chk("reset.rf_en", 32'(rf_en_o), 0);
    chk("reset.rf_sel", 32'(rf_sel_o), 0);
    chk("reset.rf_data", rf_data_o, 0);
    chk("reset.err", 32'(err_o), 0);
    chk("reset.hazard", 32'(hazard_o), 0);
    chk("reset.issue_ready", 32'(issue_ready_o), 1);
    chk("reset.rs1_data", rs1_data_o, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].av, tbl[i].ard, tbl[i].ad, tbl[i].iv, tbl[i].ird,
            tbl[i].mv, tbl[i].mrd, tbl[i].md, tbl[i].rs1, 5'd0);
      #1;
      chk($sformatf("tbl%0d.mem_ready", i), 32'(mem_ready_o), 32'(tbl[i].mrdy));
      chk($sformatf("tbl%0d.hazard", i), 32'(hazard_o), 32'(tbl[i].haz));
      chk($sformatf("tbl%0d.issue_ready", i), 32'(issue_ready_o), 32'(tbl[i].rdy));
      step;
      chk($sformatf("tbl%0d.rf_en", i), 32'(rf_en_o), 32'(tbl[i].en));
      if (tbl[i].en) begin
        chk($sformatf("tbl%0d.rf_sel", i), 32'(rf_sel_o), 32'(tbl[i].sel));
        chk($sformatf("tbl%0d.rf_data", i), rf_data_o, tbl[i].dat);
      end
      if (tbl[i].rsc) chk($sformatf("tbl%0d.rs1_data", i), rs1_data_o, tbl[i].rs1d);
      chk($sformatf("tbl%0d.err", i), 32'(err_o), 32'(tbl[i].err));
    end

    // Asynchronous reset with two loads pending and a write in flight
    drive(0,0,0, 1,13, 0,0,0, 0,0); step;
    drive(0,0,0, 1,14, 0,0,0, 0,0); step;
    drive(1,15,'h55, 0,0, 0,0,0, 0,0); step;
    drive(0,0,0, 0,0, 0,0,0, 13,14);
    #1;
    chk("pre_rst.hazard", 32'(hazard_o), 1);
    chk("pre_rst.rf_en", 32'(rf_en_o), 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("in_rst.rf_en", 32'(rf_en_o), 0);
    chk("in_rst.rf_sel", 32'(rf_sel_o), 0);
    chk("in_rst.rf_data", rf_data_o, 0);
    chk("in_rst.err", 32'(err_o), 0);
    chk("in_rst.hazard", 32'(hazard_o), 0);
    chk("in_rst.issue_ready", 32'(issue_ready_o), 1);
    step;
    #3 rst_ni = 1'b1;
    step;
    chk("post_rst.hazard", 32'(hazard_o), 0);
    chk("post_rst.rf_en", 32'(rf_en_o), 0);
    chk("post_rst.err", 32'(err_o), 0);

    // Random traffic; upstream honours hazard_o and memory returns loads in any order.
    foreach (pend[k]) pend[k] = 1'b0;
    cnt = 0; pw_en = 1'b0; pw_sel = '0; pw_data = '0;
    arch = tbrf;
    hold = 1'b0; hidx = 0; hd = '0;
    for (int c = 0; c < 2500; c++) begin
      av  = ($urandom % 10) < 4;
      ard = 5'($urandom % 8);
      ad  = $urandom;
      if (!hold && outq.size() > 0 && ($urandom % 3) != 0) begin
        hold = 1'b1;
        hidx = $urandom % outq.size();
        hd   = $urandom;
      end
      hrd = hold ? outq[hidx] : 5'd0;
      r1  = 5'($urandom % 8);
      r2  = 5'($urandom % 8);
      ird = 5'($urandom % 8);
      iv  = ($urandom % 2 == 1) && !pend[r1] && !pend[r2] && !pend[ird] && (cnt < MAXO);
      drive(av, ard, ad, iv, ird, hold, hrd, hd, r1, r2);
      #1;
      exp_haz = pend[r1] | pend[r2];
      chk("rnd.mem_ready", 32'(mem_ready_o), 32'(!av));
      chk("rnd.issue_ready", 32'(issue_ready_o), 32'(cnt < MAXO));
      chk("rnd.hazard", 32'(hazard_o), 32'(exp_haz));

      if (pw_en) arch[pw_sel] = pw_data;
      e1 = (r1 == 0) ? 32'd0 : arch[r1];
      e2 = (r2 == 0) ? 32'd0 : arch[r2];
      acc = hold && !av;
      if (av) begin
        pw_en = (ard != 0); pw_sel = ard; pw_data = ad;
      end else if (acc) begin
        pw_en = (hrd != 0); pw_sel = hrd; pw_data = hd;
      end else begin
        pw_en = 1'b0;
      end
      if (acc) begin
        outq.delete(hidx);
        pend[hrd] = 1'b0;
        cnt--;
        hold = 1'b0;
      end
      if (iv) begin
        outq.push_back(ird);
        if (ird != 0) pend[ird] = 1'b1;
        cnt++;
      end

      step;
      chk("rnd.rf_en", 32'(rf_en_o), 32'(pw_en));
      if (pw_en) begin
        chk("rnd.rf_sel", 32'(rf_sel_o), 32'(pw_sel));
        chk("rnd.rf_data", rf_data_o, pw_data);
      end
      chk("rnd.rs1_data", rs1_data_o, e1);
      chk("rnd.rs2_data", rs2_data_o, e2);
      chk("rnd.err", 32'(err_o), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
